// File: rtl/instr_fetch.sv
// Instruction fetch: one-entry line buffer in front of a single-outstanding memory port,
// handing 32-bit instructions to decode with redirect/flush support.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] next_pc,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc,
  output logic        sig_recvd,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  input  logic        id_ready
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] buf_data_q, buf_data_d;
  logic [60:0] buf_tag_q, buf_tag_d;
  logic        buf_valid_q, buf_valid_d;
  logic        kill_q, kill_d;
  logic        buf_hit;
  logic        accept;

  assign buf_hit = buf_valid_q && (buf_tag_q == pc_q[63:3]);
  assign accept  = (state_q == StHold) && id_ready && !redirect;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    buf_data_d  = buf_data_q;
    buf_tag_d   = buf_tag_q;
    buf_valid_d = buf_valid_q;
    kill_d      = kill_q;
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          state_d = StIdle;
        end else if (buf_hit) begin
          state_d = StHold;
        end else begin
          addr_d  = {pc_q[63:3], 3'b000};
          state_d = StReq;
        end
      end
      StReq: begin
        // An accepted-but-stale request must still drain; kill marks its response.
        if (redirect) kill_d = 1'b1;
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_resp_valid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = StIdle;
          end else begin
            buf_data_d  = mem_resp_data;
            buf_tag_d   = addr_q[63:3];
            buf_valid_d = 1'b1;
            state_d     = StHold;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      StHold: begin
        if (redirect) begin
          state_d = StIdle;
        end else if (id_ready) begin
          pc_d    = next_pc;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (redirect) pc_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      addr_q        <= '0;
      buf_data_q    <= '0;
      buf_tag_q     <= '0;
      buf_valid_q   <= 1'b0;
      kill_q        <= 1'b0;
      mem_req_valid <= 1'b0;
      id_valid      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      buf_data_q    <= buf_data_d;
      buf_tag_q     <= buf_tag_d;
      buf_valid_q   <= buf_valid_d;
      kill_q        <= kill_d;
      mem_req_valid <= (state_d == StReq);
      id_valid      <= (state_d == StHold);
    end
  end

  assign pc           = pc_q;
  assign mem_req_addr = addr_q;
  assign sig_recvd    = accept && !reset;
  assign id_pc        = id_valid ? pc_q : '0;
  assign id_instr     = id_valid ? (pc_q[2] ? buf_data_q[63:32] : buf_data_q[31:0]) : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a one-outstanding memory model and a handoff scoreboard.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [63:0] next_pc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] pc;
  logic        sig_recvd;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        id_ready;

  logic        rdy_en;
  logic        hold_resp;
  logic        pend;
  logic [63:0] pend_addr;
  int          n_acc;
  int          checks;
  int          failures;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;
  exp_t sb_q[$];

  instr_fetch #(.RESET_PC(64'h1000)) dut (
    .clk            (clk),
    .reset          (reset),
    .next_pc        (next_pc),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .sig_recvd      (sig_recvd),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] memf(input logic [63:0] a);
    if (a == 64'h1000) return 64'hAAAA_BBBB_1111_2222;
    return {~a[31:0], a[31:0]};
  endfunction

  // Memory: accepts a request, then answers in the following cycle unless held back.
  assign next_pc        = pc + 64'd4;
  assign mem_req_ready  = rdy_en;
  assign mem_resp_valid = pend && !hold_resp;
  assign mem_resp_data  = memf(pend_addr);

  initial begin
    pend      = 1'b0;
    pend_addr = '0;
    n_acc     = 0;
    checks    = 0;
    failures  = 0;
  end

  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) begin
      pend      <= 1'b1;
      pend_addr <= mem_req_addr;
      n_acc     <= n_acc + 1;
    end else if (mem_resp_valid) begin
      pend <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && sig_recvd) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected observed pc=%h expected=no handoff", id_pc);
      end
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_instr", {32'h0, id_instr}, {32'h0, e.instr});
        chk("sb_pc", id_pc, e.pc);
      end
    end
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    rdy_en = 1'b1; hold_resp = 1'b0;
    tick(); tick();
    chk("rst_pc", pc, 64'h1000);
    chk("rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
    chk("rst_id_valid", {63'h0, id_valid}, 64'h0);
    chk("rst_sig_recvd", {63'h0, sig_recvd}, 64'h0);
    chk("rst_id_instr", {32'h0, id_instr}, 64'h0);
    chk("rst_id_pc", id_pc, 64'h0);
    chk("rst_req_addr", mem_req_addr, 64'h0);

    // Cold miss with immediate memory
    reset = 1'b0; id_ready = 1'b1;
    sb_q.push_back('{instr: 32'h1111_2222, pc: 64'h1000});
    tick();
    chk("a_req_valid", {63'h0, mem_req_valid}, 64'h1);
    chk("a_req_addr", mem_req_addr, 64'h1000);
    chk("a_req_id_valid", {63'h0, id_valid}, 64'h0);
    tick();
    chk("a_wait_req_valid", {63'h0, mem_req_valid}, 64'h0);
    chk("a_wait_id_valid", {63'h0, id_valid}, 64'h0);
    tick();
    chk("a_id_valid", {63'h0, id_valid}, 64'h1);
    chk("a_id_pc", id_pc, 64'h1000);
    chk("a_id_instr", {32'h0, id_instr}, 64'h1111_2222);
    chk("a_sig_recvd", {63'h0, sig_recvd}, 64'h1);

    // Buffer hit on the upper word
    sb_q.push_back('{instr: 32'hAAAA_BBBB, pc: 64'h1004});
    tick();
    chk("b_pc", pc, 64'h1004);
    chk("b_idle_id_valid", {63'h0, id_valid}, 64'h0);
    tick();
    chk("b_id_valid", {63'h0, id_valid}, 64'h1);
    chk("b_id_instr", {32'h0, id_instr}, 64'hAAAA_BBBB);
    chk("b_no_req", {63'h0, mem_req_valid}, 64'h0);

    // Memory back-pressure
    rdy_en = 1'b0;
    tick();
    id_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("c_req_valid", {63'h0, mem_req_valid}, 64'h1);
      chk("c_req_addr", mem_req_addr, 64'h1008);
      chk("c_id_valid", {63'h0, id_valid}, 64'h0);
      tick();
    end
    chk("c_req_count", n_acc, 64'd1);

    // Redirect while waiting, response arrives a cycle later
    rdy_en = 1'b1; hold_resp = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 64'h2000;
    tick();
    redirect = 1'b0; hold_resp = 1'b0;
    chk("d_pc", pc, 64'h2000);
    chk("d_wait_id_valid", {63'h0, id_valid}, 64'h0);
    tick();
    chk("d_discard_id_valid", {63'h0, id_valid}, 64'h0);
    chk("d_idle_req_valid", {63'h0, mem_req_valid}, 64'h0);
    tick();
    chk("d_req_valid", {63'h0, mem_req_valid}, 64'h1);
    chk("d_req_addr", mem_req_addr, 64'h2000);

    // Redirect during the request phase; buffer must still hold the 0x1000 line
    redirect = 1'b1; redirect_pc = 64'h1004;
    tick();
    redirect = 1'b0;
    chk("e_pc", pc, 64'h1004);
    tick();
    chk("e_idle_id_valid", {63'h0, id_valid}, 64'h0);
    tick();
    chk("e_id_valid", {63'h0, id_valid}, 64'h1);
    chk("e_id_instr", {32'h0, id_instr}, 64'hAAAA_BBBB);
    chk("e_id_pc", id_pc, 64'h1004);
    chk("e_req_count", n_acc, 64'd3);

    // Decode stall, then redirect beats id_ready
    for (int i = 0; i < 3; i++) begin
      chk("f_id_valid", {63'h0, id_valid}, 64'h1);
      chk("f_id_instr", {32'h0, id_instr}, 64'hAAAA_BBBB);
      chk("f_id_pc", id_pc, 64'h1004);
      chk("f_sig_recvd", {63'h0, sig_recvd}, 64'h0);
      tick();
    end
    redirect = 1'b1; redirect_pc = 64'h3000; id_ready = 1'b1;
    #1;
    chk("f_redir_sig_recvd", {63'h0, sig_recvd}, 64'h0);
    tick();
    redirect = 1'b0; id_ready = 1'b0;
    chk("f_pc", pc, 64'h3000);
    chk("f_idle_id_valid", {63'h0, id_valid}, 64'h0);

    // Reset with a request in flight; its late response must be ignored
    hold_resp = 1'b1;
    tick();
    chk("g_req_addr", mem_req_addr, 64'h3000);
    tick();
    chk("g_wait_req_valid", {63'h0, mem_req_valid}, 64'h0);
    reset = 1'b1;
    tick();
    chk("g_rst_pc", pc, 64'h1000);
    chk("g_rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
    chk("g_rst_id_valid", {63'h0, id_valid}, 64'h0);
    chk("g_rst_addr", mem_req_addr, 64'h0);
    reset = 1'b0; hold_resp = 1'b0; id_ready = 1'b1;
    sb_q.push_back('{instr: 32'h1111_2222, pc: 64'h1000});
    tick();
    chk("g_fresh_req_valid", {63'h0, mem_req_valid}, 64'h1);
    chk("g_fresh_req_addr", mem_req_addr, 64'h1000);
    chk("g_late_id_valid", {63'h0, id_valid}, 64'h0);
    tick();
    tick();
    chk("g_hold_id_valid", {63'h0, id_valid}, 64'h1);
    chk("g_hold_id_instr", {32'h0, id_instr}, 64'h1111_2222);
    tick();

    // Low PC bits do not affect word selection
    redirect = 1'b1; redirect_pc = 64'h1007; id_ready = 1'b0;
    tick();
    redirect = 1'b0;
    tick();
    chk("h_id_instr", {32'h0, id_instr}, 64'hAAAA_BBBB);
    chk("h_id_pc", id_pc, 64'h1007);
    chk("h_sb_drained", sb_q.size(), 64'd0);
    chk("h_req_count", n_acc, 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
